// File: rtl/stream_aligner_pkg.sv
// stream_aligner_pkg: shared state encoding and mask helper for the stream aligner
package stream_aligner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Ones in the low (width - off) bits; off = 0 yields all ones for any width up to 64.
  function automatic logic [64:0] low_mask(input int width, input int off);
    return (65'd1 << (width - off)) - 65'd1;
  endfunction

endpackage

// File: rtl/stream_aligner_barrier_shifter.sv
// barrier_shifter: logarithmic barrel rotator, right or left by DIRECTION
module barrier_shifter #(
  parameter int    WIDTH     = 8,
  parameter string DIRECTION = "R",
  localparam int   SW        = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shift,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage [SW+1];

  assign stage[0] = data;

  // Each stage conditionally rotates by the power of two of its shift bit.
  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int K = 1 << s;
    logic [WIDTH-1:0] rot;
    if (DIRECTION == "R") begin : g_r
      assign rot = {stage[s][K-1:0], stage[s][WIDTH-1:K]};
    end else begin : g_l
      assign rot = {stage[s][WIDTH-1-K:0], stage[s][WIDTH-1:WIDTH-K]};
    end
    assign stage[s+1] = shift[s] ? rot : stage[s];
  end

  assign result = stage[SW];

endmodule

// File: rtl/stream_aligner.sv
// stream_aligner: strips a per-packet bit offset and emits word-aligned output words
module stream_aligner
  import stream_aligner_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int OW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OW-1:0]    cfg_offset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  state_t           state;
  logic [OW-1:0]    off_q;
  logic [WIDTH-1:0] prev_q;
  logic [OW-1:0]    shamt;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] lowmask;
  logic             can_out;
  logic             acc;
  logic             ld_s;
  logic             ld_f;

  // The packet's own offset is not registered yet on its first beat, so IDLE rotates by cfg_offset.
  assign shamt = (state == IDLE) ? cfg_offset : off_q;

  barrier_shifter #(.WIDTH(WIDTH), .DIRECTION("R")) u_rot (
    .data  (in_data),
    .shift (shamt),
    .result(rot)
  );

  assign lowmask = WIDTH'(low_mask(WIDTH, int'(off_q)));
  assign can_out = !out_valid || out_ready;
  assign in_ready = (state == IDLE) ? 1'b1 : (state == STREAM) ? can_out : 1'b0;
  assign acc = in_valid && in_ready;
  assign ld_s = (state == STREAM) && acc;
  assign ld_f = (state == FLUSH) && can_out;

  // Packet sequencing plus the rotated history word that supplies each output's low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      off_q  <= '0;
      prev_q <= '0;
    end else begin
      if (state == IDLE && acc) begin
        off_q  <= cfg_offset;
        prev_q <= rot;
        state  <= in_last ? FLUSH : STREAM;
      end
      if (ld_s) begin
        prev_q <= rot;
        if (in_last) state <= FLUSH;
      end
      if (ld_f) state <= IDLE;
    end
  end

  // Single output register; a new load takes priority over the drain of the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (ld_s || ld_f) begin
      out_valid <= 1'b1;
      out_data  <= ld_f ? (prev_q & lowmask) : ((prev_q & lowmask) | (rot & ~lowmask));
      out_last  <= ld_f;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_aligner.sv
// tb_stream_aligner: randomized and directed checks of stream_aligner against a packet-level model
module tb_stream_aligner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cfg_offset = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;

  int         checks = 0;
  int         errors = 0;
  int         mode = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pkt[$];
  logic       hold_v = 1'b0;
  logic [9:0] hold = '0;
  logic [8:0] e;

  stream_aligner #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_offset(cfg_offset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Downstream readiness: 0 always ready, 1 random, 2 stalled
  always @(posedge clk) begin
    #1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && hold_v) chk("bp_stable", {22'd0, out_valid, out_last, out_data}, {22'd0, hold});
    hold_v = rst_n && out_valid && !out_ready;
    hold = {out_valid, out_last, out_data};
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_word", {23'd0, out_last, out_data}, {23'd0, e});
      end
    end
  end

  // Reference: output k is the bit stream with off bits dropped, taken one word at a time.
  task automatic model(input int off);
    int n = pkt.size();
    for (int k = 0; k < n; k++) begin
      int two = int'(pkt[k]) + ((k + 1 < n) ? int'(pkt[k+1]) * 256 : 0);
      exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, 8'((two >> off) % 256)});
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic [2:0] c);
    logic got = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    cfg_offset = c;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 1000);
    if (!got) chk("accept_timeout", {31'd0, in_ready}, 1);
    in_valid = 1'b0;
    in_data = 8'($urandom);
    in_last = 1'($urandom);
    cfg_offset = 3'($urandom);
  endtask

  task automatic send_pkt(input int off, input int mid, input int gap_max);
    model(off);
    for (int i = 0; i < pkt.size(); i++) begin
      beat(pkt[i], i == pkt.size() - 1, (i == 0) ? 3'(off) : 3'(mid));
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    pkt = '{8'h11, 8'h22, 8'h33};
    send_pkt(0, 0, 0);
    @(negedge clk);
    chk("off0_bubble", {31'd0, in_ready}, 0);
    drain();

    pkt = '{8'h21, 8'h43, 8'h65};
    send_pkt(4, 4, 0);
    drain();

    pkt = '{8'hF8};
    send_pkt(3, 3, 0);
    @(negedge clk);
    chk("single_flush_rdy", {31'd0, in_ready}, 0);
    @(negedge clk);
    chk("single_idle_rdy", {31'd0, in_ready}, 1);
    drain();

    mode = 2;
    @(posedge clk);
    #1;
    pkt = '{8'h21, 8'h43, 8'h65};
    model(4);
    beat(8'h21, 1'b0, 3'd4);
    beat(8'h43, 1'b0, 3'd6);
    in_valid = 1'b1;
    in_data = 8'h65;
    in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_data", {24'd0, out_data}, 32'h32);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
    end
    mode = 0;
    beat(8'h65, 1'b1, 3'd1);
    drain();

    pkt = '{8'h03, 8'h80};
    send_pkt(1, 5, 0);
    pkt = '{8'h80, 8'h01};
    send_pkt(7, 5, 0);
    drain();

    pkt = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    beat(8'h5A, 1'b0, 3'd2);
    beat(8'hC3, 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pkt = '{8'hAA};
    send_pkt(0, 0, 0);
    drain();

    mode = 1;
    for (int p = 0; p < 60; p++) begin
      pkt.delete();
      repeat ($urandom_range(5, 1)) pkt.push_back(8'($urandom));
      send_pkt($urandom_range(7, 0), $urandom_range(7, 0), 2);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_aligner.md
# stream_aligner

Packet-based bit-stream realigner in front of the datapath. Strips a per-packet bit offset from the head of a WIDTH-bit word stream and emits word-aligned output words. Uses a right rotator plus a one-word history register. Valid/ready on both sides; sustains one word per cycle inside a packet.

## Interface

- WIDTH, 8, word width; power of two, ≥ 2
- OW (localparam), $clog2(WIDTH), offset width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- cfg_offset  in  OW  bit offset to drop from the head of the packet; sampled only on the first accepted beat of a packet
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  WIDTH  input word; bit 0 is the earliest bit in the stream
- in_last  in  1  final beat of the packet
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  WIDTH  aligned output word
- out_last  out  1  final output word of the packet

## Operation

- Packet {w[N-1]..w[0]} with offset off → exactly N output words: o[k] = ({w[k+1], w[k]} >> off)[WIDTH-1:0] with w[N] = 0. The final word is zero-padded at the top.
- rotR(x, s) = x rotated right by s. lowmask = (1 << (WIDTH-off)) - 1, computed WIDTH+1 bits wide; off = 0 gives all ones.
- merge(p, c) = (p & lowmask) | (c & ~lowmask).
- Registers:
  - state
  - off_q
  - prev_q: holds rotR(w[k], off_q)
  - out_valid, out_data, out_last: a single output register
- can_out = !out_valid || out_ready
- States:
  - IDLE:
    - in_ready = 1.
    - On accept: off_q ← cfg_offset; prev_q ← rotR(in_data, cfg_offset). The rotator shift input is muxed to cfg_offset in IDLE and to off_q otherwise.
    - No output.
    - Next state: FLUSH if in_last, else STREAM.
  - STREAM:
    - in_ready = can_out.
    - On accept: out_data ← merge(prev_q, rotR(in_data, off_q)); out_last ← 0; out_valid ← 1; prev_q ← rotR(in_data, off_q).
    - Next state: FLUSH if in_last.
  - FLUSH:
    - in_ready = 0.
    - When can_out: out_data ← prev_q & lowmask; out_last ← 1; out_valid ← 1; → IDLE.
- Output register: out_valid clears on out_valid && out_ready when no new load occurs in the same cycle. A load in that same cycle wins.
- cfg_offset changes while not in IDLE are ignored.
- in_data, in_last and cfg_offset are don't-care when in_valid = 0.

## Timing

- Reset values:
  - state = IDLE
  - off_q = 0, prev_q = 0
  - out_valid = 0, out_data = 0, out_last = 0
  - in_ready = 1 once rst_n deasserts
- Reset asserted mid-packet drops the partial packet immediately. out_valid falls asynchronously. The next packet starts clean.
- Latency: o[k] is valid the cycle after w[k+1] is accepted. o[N-1] is valid the cycle after FLUSH is entered with can_out.
- Throughput: 1 word/cycle within a packet. A one-cycle input bubble occurs per packet (FLUSH). A single-beat packet occupies IDLE then FLUSH.
- Backpressure: while out_valid && !out_ready, out_data and out_last stay stable and in_ready = 0 in STREAM and FLUSH. No beat is lost or duplicated.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to out_valid.

## Structure

- stream_aligner_pkg holds:
  - state enum {IDLE, STREAM, FLUSH}
  - function low_mask(width, off)
- Sub-module: one instance of the existing barrier_shifter with DIRECTION = "R" and WIDTH passed through. Its input is in_data; its shift input is the IDLE/off_q mux.
- Expected size: about 150 RTL lines.

## Test plan

All scenarios use WIDTH = 8.

- off = 0; input 0x11, 0x22, 0x33 (last); out_ready = 1 → output 0x11, 0x22, 0x33 with out_last on 0x33; one bubble cycle after the last input.
- off = 4; input 0x21, 0x43, 0x65 (last) → output 0x32, 0x54, 0x06 (last).
- Single beat; off = 3; input 0xF8 with last → output 0x1F with out_last. in_ready is 0 for exactly one cycle (FLUSH).
- off = 4 packet; hold out_ready = 0 for 3 cycles after the first output → out_data stays 0x32; in_ready = 0; on release the remaining sequence is unchanged.
- Back-to-back packets: off = 1 on 0x03, 0x80 (last), then off = 7 on 0x80, 0x01 (last). Drive cfg_offset = 5 mid-packet → output 0x01, 0x40 (last), then 0x03, 0x00 (last). The mid-packet cfg_offset value is ignored.
- Assert rst_n low after the second beat of a 4-beat packet → out_valid = 0 and state = IDLE immediately. A following packet with off = 0, 0xAA (last) → output 0xAA (last).
